// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and sizing helpers for the sequential binary-to-BCD converter
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int W_DEFAULT = 16;
    localparam int CNT_W     = $clog2(W_DEFAULT + 1);

    // Bit counter must hold the value W itself, hence W+1 states.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Smallest digit count whose range 10^d-1 covers every unsigned w-bit value.
    function automatic int bcd_digits(input int w);
        longint unsigned lim;
        int              d;
        lim = 64'd10;
        d   = 1;
        for (int i = 0; i < 20; i++) begin
            if (lim < (64'd1 << w)) begin
                lim = lim * 64'd10;
                d   = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one double-dabble digit correction cell (add 3 when digit exceeds 4)
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din > 4'd4) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble converter, one shift-and-adjust step per clock
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W      = 16,
    parameter int D      = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_bin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*D-1:0] out_bcd,
    output logic           out_neg,
    output logic           out_ovf
);

    localparam int CW = cnt_width(W);
    localparam int BW = 4 * D;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    bin_r;
    logic [BW-1:0]   bcd_r;
    logic [CW-1:0]   cnt;
    logic            neg_r;
    logic            ovf_r;
    logic [BW-1:0]   adj;
    logic            accept;
    logic            step;
    logic            in_neg;
    logic [W-1:0]    in_mag;

    for (genvar g = 0; g < D; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_r[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Negation wraps mod 2^W, so the most negative value maps to 2^(W-1).
    assign in_neg = SIGNED && in_bin[W-1];
    assign in_mag = in_neg ? (~in_bin + 1'b1) : in_bin;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r     <= '0;
            bcd_r     <= '0;
            cnt       <= '0;
            neg_r     <= 1'b0;
            ovf_r     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            if (accept) begin
                bin_r <= in_mag;
                bcd_r <= '0;
                cnt   <= CW'(W);
                neg_r <= in_neg;
                ovf_r <= 1'b0;
            end else if (step) begin
                bcd_r <= {adj[BW-2:0], bin_r[W-1]};
                bin_r <= {bin_r[W-2:0], 1'b0};
                ovf_r <= ovf_r | adj[BW-1];
                cnt   <= cnt - CW'(1);
            end
        end
    end

    assign out_bcd = bcd_r;
    assign out_neg = neg_r;
    assign out_ovf = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq across unsigned, signed and short-digit configs
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        vld_i  [3];
    logic        rdy_o  [3];
    logic [15:0] bin_i  [3];
    logic        val_o  [3];
    logic        ordy_i [3];
    logic [19:0] bcd_q  [3];
    logic [15:0] bcd4;
    logic        neg_o  [3];
    logic        ovf_o  [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Unit 0: W16 D5 unsigned, unit 1: W16 D5 signed, unit 2: W16 D4 unsigned.
    bin2bcd_seq #(.W(16), .D(5), .SIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_i[0]), .in_ready(rdy_o[0]), .in_bin(bin_i[0]),
        .out_valid(val_o[0]), .out_ready(ordy_i[0]), .out_bcd(bcd_q[0]), .out_neg(neg_o[0]), .out_ovf(ovf_o[0])
    );
    bin2bcd_seq #(.W(16), .D(5), .SIGNED(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_i[1]), .in_ready(rdy_o[1]), .in_bin(bin_i[1]),
        .out_valid(val_o[1]), .out_ready(ordy_i[1]), .out_bcd(bcd_q[1]), .out_neg(neg_o[1]), .out_ovf(ovf_o[1])
    );
    bin2bcd_seq #(.W(16), .D(4), .SIGNED(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_i[2]), .in_ready(rdy_o[2]), .in_bin(bin_i[2]),
        .out_valid(val_o[2]), .out_ready(ordy_i[2]), .out_bcd(bcd4), .out_neg(neg_o[2]), .out_ovf(ovf_o[2])
    );
    assign bcd_q[2] = {4'h0, bcd4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference computed with plain integer arithmetic.
    function automatic void model(input int u, input logic [15:0] v,
                                  output logic [19:0] bcd, output logic neg, output logic ovf);
        int mag;
        int lim;
        neg = (u == 1) && v[15];
        mag = neg ? (65536 - int'(v)) : int'(v);
        lim = (u == 2) ? 10000 : 100000;
        ovf = (mag >= lim);
        bcd = '0;
        for (int i = 0; i < 5; i++) begin
            bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        if (u == 2) bcd[19:16] = 4'h0;
    endfunction

    task automatic check_reset_state(input int u);
        check("rst_out_valid", val_o[u], 0);
        check("rst_in_ready", rdy_o[u], 1);
        check("rst_out_bcd", bcd_q[u], 0);
        check("rst_out_neg", neg_o[u], 0);
        check("rst_out_ovf", ovf_o[u], 0);
    endtask

    task automatic run(input int u, input logic [15:0] v, input int hold);
        logic [19:0] eb;
        logic        en;
        logic        eo;
        int          lat;
        model(u, v, eb, en, eo);
        bin_i[u] = v;
        vld_i[u] = 1'b1;
        lat = 0;
        while (!rdy_o[u] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_before_accept", rdy_o[u], 1);
        @(negedge clk);
        vld_i[u] = 1'b0;
        bin_i[u] = 16'($urandom);
        lat = 0;
        while (!val_o[u] && lat < 100) begin
            check("in_ready_busy", rdy_o[u], 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 16);
        check("out_valid", val_o[u], 1);
        check("out_neg", neg_o[u], en);
        check("out_ovf", ovf_o[u], eo);
        if (!eo) check("out_bcd", bcd_q[u], eb);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", val_o[u], 1);
            check("hold_in_ready", rdy_o[u], 0);
            check("hold_out_neg", neg_o[u], en);
            check("hold_out_ovf", ovf_o[u], eo);
            if (!eo) check("hold_out_bcd", bcd_q[u], eb);
        end
        ordy_i[u] = 1'b1;
        @(negedge clk);
        check("post_hs_out_valid", val_o[u], 0);
        check("post_hs_in_ready", rdy_o[u], 1);
        ordy_i[u] = 1'b0;
    endtask

    initial begin
        logic [15:0] rv;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld_i[i]  = 1'b0;
            bin_i[i]  = '0;
            ordy_i[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) check_reset_state(u);
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) check_reset_state(u);

        run(0, 16'd12345, 0);
        run(0, 16'd0, 0);
        run(0, 16'd65535, 0);
        run(1, 16'h8000, 0);
        run(1, 16'hFFFF, 0);
        run(1, 16'h7FFF, 0);
        run(1, 16'd0, 0);
        run(2, 16'd9999, 0);
        run(2, 16'd10000, 0);
        run(2, 16'd65535, 0);
        run(0, 16'd54321, 10);

        // Abort a signed conversion part-way through with an asynchronous reset.
        bin_i[1] = 16'hFFF0;
        vld_i[1] = 1'b1;
        @(negedge clk);
        vld_i[1] = 1'b0;
        repeat (7) @(negedge clk);
        check("midconv_busy", rdy_o[1], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state(1);
        run(0, 16'd42, 0);
        run(1, 16'd42, 0);

        for (int r = 0; r < 20; r++) begin
            for (int u = 0; u < 3; u++) begin
                if ($urandom_range(0, 1) == 1) rv = 16'($urandom_range(0, 9999));
                else rv = 16'($urandom);
                run(u, rv, $urandom_range(0, 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
